// File: rtl/fp_mul_pipe.sv
// fp_mul_pipe: 3-stage pipelined FP multiplier with valid/ready handshake.
// Ports: clk, rst_n, in_valid/in_ready, a_operand, b_operand, rnd_mode,
//   out_valid/out_ready, result, invalid, overflow, underflow, inexact.
module fp_mul_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a_operand,
  input  logic [EXP_W+MAN_W:0]   b_operand,
  input  logic                   rnd_mode,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   result,
  output logic                   invalid,
  output logic                   overflow,
  output logic                   underflow,
  output logic                   inexact
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int SW = MAN_W + 1;
  localparam int PW = 2 * SW;
  localparam int XW = EXP_W + 2;

  localparam logic signed [XW-1:0] BIAS = XW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [XW-1:0] EMAX = XW'((1 << EXP_W) - 1);
  localparam logic signed [XW-1:0] ONE  = XW'(1);
  localparam logic [EXP_W-1:0] E_ONES = '1;
  localparam logic [W-1:0] QNAN =
    {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic [W-1:0] MAXF =
    {1'b0, E_ONES - EXP_W'(1), {MAN_W{1'b1}}};

  logic en;
  assign en       = !(out_valid && !out_ready);
  assign in_ready = en;

  // operand capture
  logic           v0;
  logic [W-1:0]   a_q, b_q;
  logic           rnd_q;

  // stage 1: unpack / classify / multiply
  logic               sa, sb;
  logic [EXP_W-1:0]   ea, eb;
  logic [MAN_W-1:0]   fa, fb;
  logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic               nan_c, inv_c1, inf_c, zero_c;
  logic [PW-1:0]      prod_c;
  logic signed [XW-1:0] esum_c;

  assign {sa, ea, fa} = a_q;
  assign {sb, eb, fb} = b_q;
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (ea == E_ONES) && (fa == '0);
  assign b_inf  = (eb == E_ONES) && (fb == '0);
  assign a_nan  = (ea == E_ONES) && (fa != '0);
  assign b_nan  = (eb == E_ONES) && (fb != '0);

  // special cases resolved here in priority order so they stay one-hot
  assign nan_c  = a_nan || b_nan;
  assign inv_c1 = !nan_c && ((a_inf && b_zero) || (b_inf && a_zero));
  assign inf_c  = !nan_c && !inv_c1 && (a_inf || b_inf);
  assign zero_c = !nan_c && !inv_c1 && !inf_c && (a_zero || b_zero);

  assign prod_c = PW'({1'b1, fa}) * PW'({1'b1, fb});
  assign esum_c = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;

  logic                 v1, s1_sign, s1_rnd;
  logic                 s1_nan, s1_inv, s1_inf, s1_zero;
  logic signed [XW-1:0] s1_exp;
  logic [PW-1:0]        s1_prod;

  // stage 2: normalise
  logic [PW-2:0] norm;
  assign norm = s1_prod[PW-1] ? s1_prod[PW-2:0]
                              : {s1_prod[PW-3:0], 1'b0};

  logic                 v2, s2_sign, s2_rnd, s2_g, s2_s;
  logic                 s2_nan, s2_inv, s2_inf, s2_zero;
  logic signed [XW-1:0] s2_exp;
  logic [MAN_W-1:0]     s2_frac;

  // stage 3: round / pack / flags
  logic                 inc;
  logic [MAN_W:0]       frac_rnd;
  logic signed [XW-1:0] exp_fin;
  logic [W-1:0]         res_c;
  logic                 inv_c, ovf_c, unf_c, inx_c;

  always_comb begin
    inc      = !s2_rnd && s2_g && (s2_s || s2_frac[0]);
    frac_rnd = {1'b0, s2_frac} + {{MAN_W{1'b0}}, inc};
    exp_fin  = s2_exp + $signed({{(XW-1){1'b0}}, frac_rnd[MAN_W]});
    res_c    = {s2_sign, exp_fin[EXP_W-1:0], frac_rnd[MAN_W-1:0]};
    inv_c    = 1'b0;
    ovf_c    = 1'b0;
    unf_c    = 1'b0;
    inx_c    = s2_g || s2_s;
    priority case (1'b1)
      s2_nan: begin
        res_c = QNAN;
        inx_c = 1'b0;
      end
      s2_inv: begin
        res_c = QNAN;
        inv_c = 1'b1;
        inx_c = 1'b0;
      end
      s2_inf: begin
        res_c = {s2_sign, E_ONES, {MAN_W{1'b0}}};
        inx_c = 1'b0;
      end
      s2_zero: begin
        res_c = {s2_sign, {(W-1){1'b0}}};
        inx_c = 1'b0;
      end
      (exp_fin >= EMAX): begin
        ovf_c = 1'b1;
        inx_c = 1'b1;
        res_c = s2_rnd ? {s2_sign, MAXF[W-2:0]}
                       : {s2_sign, E_ONES, {MAN_W{1'b0}}};
      end
      (exp_fin <= 0): begin
        unf_c = 1'b1;
        inx_c = 1'b1;
        res_c = {s2_sign, {(W-1){1'b0}}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v0        <= 1'b0;
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      invalid   <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      inexact   <= 1'b0;
    end else if (en) begin
      v0 <= in_valid;
      if (in_valid) begin
        a_q   <= a_operand;
        b_q   <= b_operand;
        rnd_q <= rnd_mode;
      end
      v1 <= v0;
      if (v0) begin
        s1_sign <= sa ^ sb;
        s1_rnd  <= rnd_q;
        s1_exp  <= esum_c;
        s1_prod <= prod_c;
        s1_nan  <= nan_c;
        s1_inv  <= inv_c1;
        s1_inf  <= inf_c;
        s1_zero <= zero_c;
      end
      v2 <= v1;
      if (v1) begin
        s2_sign <= s1_sign;
        s2_rnd  <= s1_rnd;
        s2_exp  <= s1_prod[PW-1] ? s1_exp + ONE : s1_exp;
        s2_frac <= norm[PW-2:MAN_W+1];
        s2_g    <= norm[MAN_W];
        s2_s    <= |norm[MAN_W-1:0];
        s2_nan  <= s1_nan;
        s2_inv  <= s1_inv;
        s2_inf  <= s1_inf;
        s2_zero <= s1_zero;
      end
      out_valid <= v2;
      if (v2) begin
        result    <= res_c;
        invalid   <= inv_c;
        overflow  <= ovf_c;
        underflow <= unf_c;
        inexact   <= inx_c;
      end
    end
  end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// tb_fp_mul_pipe: directed vector bench for fp_mul_pipe.
// Covers FP32 table, latency, backpressure, reset flush, half precision.
module tb_fp_mul_pipe;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        rnd;
    logic [31:0] res;
    logic [3:0]  flg;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a_operand = '0;
  logic [31:0] b_operand = '0;
  logic        rnd_mode = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        invalid, overflow, underflow, inexact;

  logic        h_in_valid = 1'b0;
  logic        h_in_ready;
  logic [15:0] h_a = '0;
  logic [15:0] h_b = '0;
  logic        h_rnd = 1'b0;
  logic        h_out_valid;
  logic        h_out_ready = 1'b1;
  logic [15:0] h_result;
  logic        h_inv, h_ovf, h_unf, h_inx;

  int checks = 0;
  int errors = 0;
  int out_count = 0;

  logic [31:0] cur_res = '0;
  logic [3:0]  cur_flg = '0;
  logic [35:0] exp_q[$];
  vec_t        tbl[12];

  always #5 clk = ~clk;

  fp_mul_pipe dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a_operand(a_operand), .b_operand(b_operand),
    .rnd_mode(rnd_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .invalid(invalid), .overflow(overflow),
    .underflow(underflow), .inexact(inexact)
  );

  fp_mul_pipe #(.EXP_W(5), .MAN_W(10)) dut_h (
    .clk(clk), .rst_n(rst_n),
    .in_valid(h_in_valid), .in_ready(h_in_ready),
    .a_operand(h_a), .b_operand(h_b),
    .rnd_mode(h_rnd),
    .out_valid(h_out_valid), .out_ready(h_out_ready),
    .result(h_result), .invalid(h_inv), .overflow(h_ovf),
    .underflow(h_unf), .inexact(h_inx)
  );

  task automatic check(input string name, input logic [35:0] got,
                       input logic [35:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // record expectation when an input transfer is seen
  always @(negedge clk)
    if (rst_n && in_valid && in_ready)
      exp_q.push_back({cur_res, cur_flg});

  // compare every output transfer against the oldest expectation
  always @(negedge clk)
    if (rst_n && out_valid && out_ready) begin
      out_count++;
      if (exp_q.size() == 0) begin
        check("spurious_out", {4'b0, result}, 36'h0);
      end else begin
        logic [35:0] e;
        e = exp_q.pop_front();
        check("result", {4'b0, result}, {4'b0, e[35:4]});
        check("flags", {32'b0, invalid, overflow, underflow, inexact},
              {32'b0, e[3:0]});
      end
    end

  task automatic send(input vec_t v);
    logic acc;
    int   n;
    a_operand = v.a;
    b_operand = v.b;
    rnd_mode  = v.rnd;
    cur_res   = v.res;
    cur_flg   = v.flg;
    in_valid  = 1'b1;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) check("send_timeout", 36'h1, 36'h0);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain", 36'(exp_q.size()), 36'h0);
  endtask

  task automatic hsend(input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] r, input logic [3:0] f);
    int n;
    h_a = a;
    h_b = b;
    h_rnd = 1'b0;
    h_in_valid = 1'b1;
    @(posedge clk);
    #1;
    h_in_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!h_out_valid && n < 20);
    check("h_valid", {35'b0, h_out_valid}, 36'h1);
    check("h_result", {20'b0, h_result}, {20'b0, r});
    check("h_flags", {32'b0, h_inv, h_ovf, h_unf, h_inx}, {32'b0, f});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{32'h3FC00000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000};
    tbl[1]  = '{32'h3F800001, 32'h3FC00000, 1'b0, 32'h3FC00002, 4'b0001};
    tbl[2]  = '{32'h3F800001, 32'h3FC00000, 1'b1, 32'h3FC00001, 4'b0001};
    tbl[3]  = '{32'h7F000000, 32'h7F000000, 1'b0, 32'h7F800000, 4'b0101};
    tbl[4]  = '{32'h7F000000, 32'h7F000000, 1'b1, 32'h7F7FFFFF, 4'b0101};
    tbl[5]  = '{32'h00800000, 32'h00800000, 1'b0, 32'h00000000, 4'b0011};
    tbl[6]  = '{32'h7F800000, 32'h00000000, 1'b0, 32'h7FC00000, 4'b1000};
    tbl[7]  = '{32'hFF800000, 32'h40000000, 1'b0, 32'hFF800000, 4'b0000};
    tbl[8]  = '{32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0000};
    tbl[9]  = '{32'h80000000, 32'h3F800000, 1'b0, 32'h80000000, 4'b0000};
    tbl[10] = '{32'h40400000, 32'h40400000, 1'b0, 32'h41100000, 4'b0000};
    tbl[11] = '{32'hBF800000, 32'h3F800000, 1'b0, 32'hBF800000, 4'b0000};

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    @(negedge clk);
    check("rst_out_valid", {35'b0, out_valid}, 36'h0);
    check("rst_in_ready", {35'b0, in_ready}, 36'h1);
    check("rst_result", {4'b0, result}, 36'h0);
    check("rst_flags", {32'b0, invalid, overflow, underflow, inexact},
          36'h0);

    // latency: accept at edge 0, out_valid after edge 3
    @(posedge clk);
    #1;
    a_operand = tbl[0].a;
    b_operand = tbl[0].b;
    rnd_mode  = tbl[0].rnd;
    cur_res   = tbl[0].res;
    cur_flg   = tbl[0].flg;
    in_valid  = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("lat_early", {35'b0, out_valid}, 36'h0);
      @(posedge clk);
    end
    @(negedge clk);
    check("lat_on_time", {35'b0, out_valid}, 36'h1);
    drain();

    // full table back-to-back
    for (int i = 0; i < 12; i++) send(tbl[i]);
    drain();

    // backpressure: 5 ops, stall 4 cycles after first result
    begin
      int c0;
      c0 = out_count;
      fork
        begin
          for (int i = 0; i < 5; i++) send(tbl[i + 1]);
        end
        begin
          logic [31:0] held;
          int n;
          n = 0;
          do begin
            @(posedge clk);
            #1;
            n++;
          end while (!out_valid && n < 50);
          held = result;
          out_ready = 1'b0;
          repeat (4) begin
            @(negedge clk);
            check("bp_in_ready", {35'b0, in_ready}, 36'h0);
            check("bp_valid_held", {35'b0, out_valid}, 36'h1);
            check("bp_result_held", {4'b0, result}, {4'b0, held});
            @(posedge clk);
            #1;
          end
          out_ready = 1'b1;
        end
      join
      drain();
      check("bp_count", 36'(out_count - c0), 36'd5);
    end

    // reset mid-operation flushes both in-flight ops
    send(tbl[3]);
    send(tbl[7]);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    exp_q.delete();
    begin
      int c1;
      c1 = out_count;
      @(negedge clk);
      check("mid_rst_valid", {35'b0, out_valid}, 36'h0);
      check("mid_rst_result", {4'b0, result}, 36'h0);
      check("mid_rst_flags",
            {32'b0, invalid, overflow, underflow, inexact}, 36'h0);
      check("mid_rst_in_ready", {35'b0, in_ready}, 36'h1);
      repeat (6) @(negedge clk);
      check("mid_rst_no_out", 36'(out_count - c1), 36'h0);
    end

    // half precision instance
    hsend(16'h3E00, 16'h4000, 16'h4200, 4'b0000);
    hsend(16'h7800, 16'h7800, 16'h7C00, 4'b0101);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_mul_pipe.md
Name: fp_mul_pipe

Overview:
- Parametrised, 3-stage pipelined IEEE-754-style floating-point multiplier with valid/ready handshake on input and output.
- Successor to the team's single-cycle FP32 multiplier, adding:
  - configurable exponent and mantissa widths
  - selectable rounding (round-to-nearest-even or truncate)
  - full special-value handling (NaN, infinity, zero)
  - a sticky-free per-result flag set
- Sits in the Newton-Raphson datapath between operand sequencing and the accumulate/compare stages.

Parameters:
- EXP_W, 8, exponent field width; BIAS = 2^(EXP_W-1)-1.
- MAN_W, 23, stored mantissa (fraction) width; word width W = 1+EXP_W+MAN_W.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, synchronous active-low reset.
- in_valid, input, 1, operands a/b/rnd_mode valid this cycle.
- in_ready, output, 1, block accepts input this cycle.
- a_operand, input, W, multiplicand {sign, exponent, fraction}.
- b_operand, input, W, multiplier.
- rnd_mode, input, 1, 0 = round-to-nearest-even, 1 = round-toward-zero; captured with the operands.
- out_valid, output, 1, result/flags valid.
- out_ready, input, 1, downstream accepts result.
- result, output, W, packed product.
- invalid, output, 1, inf*0 occurred.
- overflow, output, 1, finite result exceeded range.
- underflow, output, 1, nonzero exact result below min normal, flushed to zero.
- inexact, output, 1, rounding discarded nonzero bits, or overflow/underflow occurred.

Behaviour:
- Reset (rst_n=0 at clk edge):
  - all stage valid bits cleared; out_valid=0.
  - result=0 and all flags=0.
  - in_ready=1 in the first cycle after reset.
  - Reset mid-operation discards all in-flight operations; no partial result appears.
- Handshake and stall:
  - Global advance enable en = !(out_valid && !out_ready); in_ready = en.
  - Transfer in on in_valid && in_ready; transfer out on out_valid && out_ready.
  - When en=0 every pipeline register holds, and result/flags stay stable while out_valid=1.
  - Bubbles propagate as invalid stages.
  - Throughput is 1 op/cycle when out_ready=1.
- Latency: an operand accepted at edge N gives out_valid=1 after edge N+3 when there is no stall.
- Stage 1, unpack/classify/multiply:
  - sign = sa^sb.
  - exp==0 means zero; subnormal inputs are flushed to zero (DAZ).
  - exp all-ones with fraction 0 means inf; with fraction nonzero means NaN.
  - Significands are {1,frac}, each (MAN_W+1) bits, giving a 2(MAN_W+1)-bit product.
  - Exponent sum ea+eb-BIAS is computed in signed EXP_W+2 bits.
- Stage 2, normalise:
  - If the product MSB is set, exponent +1; otherwise shift left 1.
  - Extract the MAN_W-bit kept fraction, guard bit G (next bit) and sticky S (OR of all remaining bits).
- Stage 3, round/pack/flags:
  - RNE: increment when G && (S || LSB). RTZ: never increment.
  - Fraction carry-out from rounding: fraction becomes 0 and exponent +1.
  - inexact = G||S for normal results.
  - If final exponent >= 2^EXP_W-1: overflow=1, inexact=1.
    - RNE result = signed inf.
    - RTZ result = signed max finite (exp all-ones-minus-1, fraction all-ones).
  - If final exponent <= 0: underflow=1, inexact=1, result = signed zero (FTZ).
- Special-value priority, highest first; none of these cases raises overflow, underflow or inexact:
  1. Any NaN input gives the canonical qNaN {0, all-ones, 1, zeros}; invalid=0.
  2. inf*0 gives the canonical qNaN; invalid=1.
  3. inf*(finite or inf) gives signed inf.
  4. zero*finite gives signed zero.
- Flags describe only the current result; they are not sticky across results.
- All arithmetic widths derive from EXP_W/MAN_W; no FP32-specific constants are used.

Test Plan:
- Basic multiply, default parameters, RNE, out_ready=1: a=0x3FC00000, b=0x40000000 at edge 0 -> out_valid at edge 3, result=0x40400000, all flags 0. Then stream 4 back-to-back ops -> 4 consecutive valid results in order.
- Rounding: a=0x3F800001, b=0x3FC00000:
  - RNE -> 0x3FC00002, inexact=1.
  - RTZ -> 0x3FC00001, inexact=1.
- Overflow/underflow:
  - 0x7F000000*0x7F000000, RNE -> 0x7F800000, overflow=1, inexact=1.
  - Same operands, RTZ -> 0x7F7FFFFF.
  - 0x00800000*0x00800000 -> 0x00000000, underflow=1, inexact=1.
- Specials:
  - 0x7F800000*0x00000000 -> 0x7FC00000, invalid=1.
  - 0xFF800000*0x40000000 -> 0xFF800000, no flags.
  - 0x7FC00001*0x3F800000 -> 0x7FC00000, invalid=0.
  - 0x80000000*0x3F800000 -> 0x80000000.
- Backpressure: stream 5 ops, hold out_ready=0 for 4 cycles after first out_valid -> in_ready=0 while stalled, result held stable, no op lost or duplicated, and all 5 results emerge in order once out_ready=1.
- Reset mid-operation: accept 2 ops, assert rst_n=0 for one edge -> out_valid=0, result=0, flags 0, in_ready=1 the next cycle, and neither op ever appears at the output.
- Parameter sweep: EXP_W=5, MAN_W=10 (half precision): 0x3E00*0x4000 -> 0x4200; 0x7800*0x7800 -> 0x7C00 with overflow=1.
